// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver.
// A prescaler paces one digit slot per REFRESH_DIV clocks. The digit index walks 0..3, and a
// full walk is one frame. New symbol codes are held in a pending register and reach the
// displayed shadow copy only at a frame boundary, so a frame never mixes old and new digits.
// Selected digits can blink with a half-period of BLINK_FRAMES frames.
module ssd_scan_driver #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [19:0] ssd,
    input  logic        load,
    input  logic [3:0]  blink_en,
    output logic [3:0]  AN,
    output logic [6:0]  seven_out,
    output logic        frame_done,
    output logic        pending
);

    localparam int unsigned PresW  = $clog2(REFRESH_DIV);
    localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PresW-1:0]  PresLast  = PresW'(REFRESH_DIV - 1);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_FRAMES - 1);

    // Code 16 in every digit position, which decodes to a blank digit.
    localparam logic [19:0] BlankWord = 20'h84210;
    localparam logic [6:0]  SegBlank  = 7'h7F;

    // Active-low segment decode, bit 6 = a ... bit 0 = g.
    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'd0:    seg = 7'h01;
            5'd1:    seg = 7'h4F;
            5'd2:    seg = 7'h12;
            5'd3:    seg = 7'h06;
            5'd4:    seg = 7'h4C;
            5'd5:    seg = 7'h24;
            5'd6:    seg = 7'h20;
            5'd7:    seg = 7'h0F;
            5'd8:    seg = 7'h00;
            5'd9:    seg = 7'h04;
            5'd10:   seg = 7'h08;
            5'd11:   seg = 7'h60;
            5'd12:   seg = 7'h31;
            5'd13:   seg = 7'h42;
            5'd14:   seg = 7'h30;
            5'd15:   seg = 7'h38;
            5'd17:   seg = 7'h7E;  // '-'
            5'd18:   seg = 7'h18;  // 'P'
            5'd19:   seg = 7'h6A;  // 'n'
            5'd20:   seg = 7'h62;  // 'o'
            default: seg = SegBlank;
        endcase
        return seg;
    endfunction

    logic [PresW-1:0]  presc_q, presc_d;
    logic [1:0]        idx_q, idx_d;
    logic [19:0]       pend_val_q, pend_val_d;
    logic              pending_q, pending_d;
    logic [19:0]       shadow_q, shadow_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              phase_q, phase_d;
    logic [3:0]        blink_q, blink_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              frame_done_q, frame_done_d;

    logic       slot_end;
    logic       frame_end;
    logic [4:0] cur_code;

    assign slot_end  = (presc_q == PresLast);
    assign frame_end = slot_end && (idx_q == 2'd3);

    // Prescaler and digit index next state.
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (slot_end) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end else begin
            presc_d = presc_q + PresW'(1);
        end
    end

    // Pending/shadow handoff: a load in the boundary cycle bypasses the pending stage.
    always_comb begin
        pend_val_d = pend_val_q;
        pending_d  = pending_q;
        shadow_d   = shadow_q;
        if (load) begin
            pend_val_d = ssd;
        end
        if (frame_end) begin
            pending_d = 1'b0;
            if (load) begin
                shadow_d = ssd;
            end else if (pending_q) begin
                shadow_d = pend_val_q;
            end
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    // Blink phase counts frame boundaries; blink_en is sampled once per slot.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        blink_d     = blink_q;
        if (slot_end) begin
            blink_d = blink_en;
        end
        if (frame_end) begin
            if (blink_cnt_q == BlinkLast) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BlinkW'(1);
            end
        end
    end

    // Symbol code of the digit currently being scanned.
    always_comb begin
        cur_code = shadow_q[4:0];
        unique case (idx_q)
            2'd0: cur_code = shadow_q[4:0];
            2'd1: cur_code = shadow_q[9:5];
            2'd2: cur_code = shadow_q[14:10];
            2'd3: cur_code = shadow_q[19:15];
        endcase
    end

    // Output next state; anodes are all off during the first clock of each slot.
    always_comb begin
        an_d         = (presc_q == '0) ? 4'hF : ~(4'b0001 << idx_q);
        seg_d        = (phase_q && blink_q[idx_q]) ? SegBlank : seg_decode(cur_code);
        frame_done_d = frame_end;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            presc_q      <= '0;
            idx_q        <= 2'd0;
            pend_val_q   <= BlankWord;
            pending_q    <= 1'b0;
            shadow_q     <= BlankWord;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b0;
            blink_q      <= 4'h0;
            an_q         <= 4'hF;
            seg_q        <= SegBlank;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pending_q    <= pending_d;
            shadow_q     <= shadow_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            blink_q      <= blink_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign AN         = an_q;
    assign seven_out  = seg_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule
